spram_stream_reader: RTL and testbench

Read-side controller for the single-port RAM buffer: tracks the writer's pointer, issues RAM reads whenever the port is free and words are pending, and presents the data as a valid/ready stream. It sits between the `spram` port-address mux and any downstream consumer. A 2-entry output buffer absorbs the RAM's 1-cycle read latency, so the stream runs at one word per cycle when write traffic allows.

---
 rtl/spram_stream_reader.sv | 137 +++++++++++++
 tb/tb_spram_stream_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_stream_reader.sv
// spram_stream_reader: read-side controller for the single-port RAM buffer.
// Follows the writer pointer, issues RAM reads whenever the port is free and
// words are pending, and presents the data as a valid/ready stream through a
// 2-entry output buffer that absorbs the 1-cycle RAM read latency.
// Optional build macro: SPRAM_RD_GRAY_EN (Gray-coded writer/reader pointers).
module spram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_ena,
    input  logic [ADDR_WIDTH:0]   i_wr_ptr,
    output logic                  o_rd_req,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [ADDR_WIDTH:0]   o_rd_ptr,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_HOLD
    } state_t;

    logic [PW-1:0]         wr_bin;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_next;
    logic                  inflight;
    logic [1:0]            ocnt;
    logic                  head;
    logic                  tail;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic                  pop;
    logic [2:0]            occ;
    logic                  issue;
    state_t                state;

`ifdef SPRAM_RD_GRAY_EN
    logic [PW-1:0] rd_gray;

    // Gray-to-binary conversion of the writer pointer: b[i] = XOR of g[N:i]
    always_comb begin
        wr_bin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wr_bin[i] = ^(i_wr_ptr >> i);
        end
    end

    // Registered Gray copy of the reader pointer for the writer's full check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_gray <= '0;
        end else begin
            rd_gray <= rd_next ^ (rd_next >> 1);
        end
    end

    assign o_rd_ptr = rd_gray;
`else
    assign wr_bin   = i_wr_ptr;
    assign o_rd_ptr = rd_ptr;
`endif

    // Occupancy after this cycle's push/pop; a read may issue only if it
    // leaves room in the 2-entry buffer for the word it will return.
    assign pop       = m_valid & m_ready;
    assign occ       = 3'(ocnt) + 3'(inflight) - 3'(pop);
    assign o_empty   = (rd_ptr == wr_bin);
    assign o_level   = wr_bin - rd_ptr;
    assign issue     = !o_empty && !i_wr_ena && (occ < 3'd2);
    assign o_rd_req  = issue;
    assign o_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign rd_next   = issue ? (rd_ptr + PW'(1)) : rd_ptr;
    assign m_valid   = (ocnt != 2'd0);
    assign m_data    = obuf[head];

    // Read pointer, in-flight flag and output buffer bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            inflight <= 1'b0;
            ocnt     <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            obuf[0]  <= '0;
            obuf[1]  <= '0;
        end else begin
            rd_ptr   <= rd_next;
            inflight <= issue;
            ocnt     <= occ[1:0];
            if (inflight) begin
                obuf[tail] <= i_rd_data;
                tail       <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    // Stream state tracking derived from buffer occupancy and pointer status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!o_empty) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (occ == 3'd2) begin
                        state <= ST_HOLD;
                    end else if (occ == 3'd0 && o_empty) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        state <= ST_STREAM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_stream_reader.sv
// Directed bench for spram_stream_reader: a wide instance (ADDR_WIDTH=8) for
// latency, backpressure and port-contention cases, and a narrow one
// (ADDR_WIDTH=2) for full/wrap behaviour. Written words go into a scoreboard
// and are popped when the stream hands them over.
module tb_spram_stream_reader;

    localparam int unsigned AW_A = 8;
    localparam int unsigned AW_B = 2;
    localparam int unsigned DW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            wr_ena_a = 1'b0;
    logic [AW_A:0]   wr_ptr_a = '0;
    logic            rd_req_a;
    logic [AW_A-1:0] rd_addr_a;
    logic [DW-1:0]   rd_data_a = '0;
    logic [AW_A:0]   rd_ptr_a;
    logic            empty_a;
    logic [AW_A:0]   level_a;
    logic            m_valid_a;
    logic [DW-1:0]   m_data_a;
    logic            m_ready_a = 1'b0;

    logic            wr_ena_b = 1'b0;
    logic [AW_B:0]   wr_ptr_b = '0;
    logic            rd_req_b;
    logic [AW_B-1:0] rd_addr_b;
    logic [DW-1:0]   rd_data_b = '0;
    logic [AW_B:0]   rd_ptr_b;
    logic            empty_b;
    logic [AW_B:0]   level_b;
    logic            m_valid_b;
    logic [DW-1:0]   m_data_b;
    logic            m_ready_b = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   exp_a [$];
    logic [DW-1:0]   exp_b [$];
    logic [AW_A-1:0] exp_addr_a = '0;
    logic [AW_B-1:0] exp_addr_b = '0;
    logic [DW-1:0]   mem_a [1 << AW_A];
    logic [DW-1:0]   mem_b [1 << AW_B];

    spram_stream_reader #(.ADDR_WIDTH(AW_A), .DATA_WIDTH(DW)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .i_wr_ena  (wr_ena_a),
        .i_wr_ptr  (wr_ptr_a),
        .o_rd_req  (rd_req_a),
        .o_rd_addr (rd_addr_a),
        .i_rd_data (rd_data_a),
        .o_rd_ptr  (rd_ptr_a),
        .o_empty   (empty_a),
        .o_level   (level_a),
        .m_valid   (m_valid_a),
        .m_data    (m_data_a),
        .m_ready   (m_ready_a)
    );

    spram_stream_reader #(.ADDR_WIDTH(AW_B), .DATA_WIDTH(DW)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .i_wr_ena  (wr_ena_b),
        .i_wr_ptr  (wr_ptr_b),
        .o_rd_req  (rd_req_b),
        .o_rd_addr (rd_addr_b),
        .i_rd_data (rd_data_b),
        .o_rd_ptr  (rd_ptr_b),
        .o_empty   (empty_b),
        .o_level   (level_b),
        .m_valid   (m_valid_b),
        .m_data    (m_data_b),
        .m_ready   (m_ready_b)
    );

    always #5 clk = ~clk;

    // RAM models with one cycle of read latency
    always @(posedge clk) begin
        if (rd_req_a) rd_data_a <= mem_a[rd_addr_a];
        if (rd_req_b) rd_data_b <= mem_b[rd_addr_b];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Read addresses must run sequentially; stream words must match the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_req_a) begin
                check("addr_a", 64'(rd_addr_a), 64'(exp_addr_a));
                exp_addr_a = exp_addr_a + 8'd1;
            end
            if (rd_req_b) begin
                check("addr_b", 64'(rd_addr_b), 64'(exp_addr_b));
                exp_addr_b = exp_addr_b + 2'd1;
            end
            if (m_valid_a && m_ready_a) begin
                if (exp_a.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL data_a got=0x%0h exp=none", m_data_a);
                end else begin
                    check("data_a", 64'(m_data_a), 64'(exp_a.pop_front()));
                end
            end
            if (m_valid_b && m_ready_b) begin
                if (exp_b.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL data_b got=0x%0h exp=none", m_data_b);
                end else begin
                    check("data_b", 64'(m_data_b), 64'(exp_b.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            mem_a[wr_ptr_a[AW_A-1:0]] = d;
            exp_a.push_back(d);
            wr_ptr_a = wr_ptr_a + 9'd1;
        end
    endtask

    task automatic push_b(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            mem_b[wr_ptr_b[AW_B-1:0]] = d;
            exp_b.push_back(d);
            wr_ptr_b = wr_ptr_b + 3'd1;
        end
    endtask

    task automatic drain_b();
        for (int i = 0; i < 30 && !(exp_b.size() == 0 && !m_valid_b && empty_b); i++) begin
            step();
        end
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog expired total=%0d bad=%0d", total, bad);
    end

    initial begin
        int nreq;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_empty_a", 64'(empty_a), 64'(1));
        check("rst_valid_a", 64'(m_valid_a), 64'(0));
        check("rst_rdptr_a", 64'(rd_ptr_a), 64'(0));
        check("rst_level_a", 64'(level_a), 64'(0));
        check("rst_req_a", 64'(rd_req_a), 64'(0));
        check("rst_data_a", 64'(m_data_a), 64'(0));
        check("rst_empty_b", 64'(empty_b), 64'(1));
        check("rst_valid_b", 64'(m_valid_b), 64'(0));
        step();
        rst = 1'b0;
        step();

        // Four words at once, consumer always ready: back-to-back reads and words
        m_ready_a = 1'b1;
        push_a(4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("burst_req_a", 64'(rd_req_a), 64'(c < 4));
            check("burst_vld_a", 64'(m_valid_a), 64'(c >= 2 && c < 6));
            step();
        end
        @(negedge clk);
        check("burst_level_a", 64'(level_a), 64'(0));
        check("burst_empty_a", 64'(empty_a), 64'(1));
        check("burst_rdptr_a", 64'(rd_ptr_a), 64'(4));
        check("burst_sb_a", 64'(exp_a.size()), 64'(0));
        step();

        // Backpressure: only two reads fit, the rest follow once ready rises
        m_ready_a = 1'b0;
        push_a(4);
        nreq = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_req_a) nreq++;
            step();
        end
        @(negedge clk);
        check("bp_nreq_a", 64'(nreq), 64'(2));
        check("bp_level_a", 64'(level_a), 64'(2));
        check("bp_valid_a", 64'(m_valid_a), 64'(1));
        check("bp_hold1_a", 64'(m_data_a), 64'(exp_a[0]));
        step();
        @(negedge clk);
        check("bp_hold2_a", 64'(m_data_a), 64'(exp_a[0]));
        step();
        m_ready_a = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("bp_vld_a", 64'(m_valid_a), 64'(c < 4));
            step();
        end
        @(negedge clk);
        check("bp_sb_a", 64'(exp_a.size()), 64'(0));
        check("bp_empty_a", 64'(empty_a), 64'(1));
        step();

        // Writer holds the port every other cycle: reads only in free cycles
        push_a(6);
        for (int c = 0; c < 16; c++) begin
            wr_ena_a = (c % 2 == 0);
            @(negedge clk);
            check("wr_ena_req_a", 64'(rd_req_a), 64'((c % 2 == 1) && (c < 12)));
            step();
        end
        wr_ena_a = 1'b0;
        @(negedge clk);
        check("wr_ena_sb_a", 64'(exp_a.size()), 64'(0));
        check("wr_ena_level_a", 64'(level_a), 64'(0));
        step();

        // Narrow buffer: fill to capacity, drain, then repeat across the wrap
        push_b(4);
        @(negedge clk);
        check("full_level_b", 64'(level_b), 64'(4));
        check("full_rdptr_b", 64'(rd_ptr_b), 64'(0));
        check("full_empty_b", 64'(empty_b), 64'(0));
        step();
        m_ready_b = 1'b1;
        drain_b();
        @(negedge clk);
        check("b1_sb_b", 64'(exp_b.size()), 64'(0));
        check("b1_rdptr_b", 64'(rd_ptr_b), 64'(4));
        check("b1_empty_b", 64'(empty_b), 64'(1));
        step();
        m_ready_b = 1'b0;
        push_b(4);
        @(negedge clk);
        check("b2_wrptr_level_b", 64'(level_b), 64'(4));
        check("b2_empty_b", 64'(empty_b), 64'(0));
        step();
        m_ready_b = 1'b1;
        drain_b();
        @(negedge clk);
        check("wrap_sb_b", 64'(exp_b.size()), 64'(0));
        check("wrap_rdptr_b", 64'(rd_ptr_b), 64'(0));
        check("wrap_empty_b", 64'(empty_b), 64'(1));
        check("wrap_level_b", 64'(level_b), 64'(0));
        step();

        // Reset while a read is in flight and a word is buffered
        m_ready_a = 1'b0;
        push_a(4);
        step();
        step();
        rst = 1'b1;
        wr_ptr_a = '0;
        exp_a.delete();
        exp_addr_a = '0;
        @(negedge clk);
        check("midrst_valid_a", 64'(m_valid_a), 64'(0));
        check("midrst_rdptr_a", 64'(rd_ptr_a), 64'(0));
        check("midrst_data_a", 64'(m_data_a), 64'(0));
        check("midrst_level_a", 64'(level_a), 64'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_valid_a", 64'(m_valid_a), 64'(0));
        check("postrst_data_a", 64'(m_data_a), 64'(0));
        step();
        m_ready_a = 1'b1;
        push_a(3);
        repeat (8) step();
        @(negedge clk);
        check("restart_sb_a", 64'(exp_a.size()), 64'(0));
        check("restart_rdptr_a", 64'(rd_ptr_a), 64'(3));
        check("restart_empty_a", 64'(empty_a), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
